// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared constants and handshake state encoding for the UART
//            transmit buffer and its byte FIFO.
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Default FIFO depth is 2**DEFAULT_DEPTH_LOG2 bytes.
  localparam int DEFAULT_DEPTH_LOG2 = 4;

  // Transmitter handshake states.
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SEND    = 2'd1,
    S_RELEASE = 2'd2
  } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_byte_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_byte_fifo
// Brief    : Synchronous byte FIFO with push/pop and occupancy count.
//            Full/empty come from the count, so pointer wrap is unambiguous.
//            A push while full or a pop while empty is ignored.
// Revision : 1.0 - initial release
// ============================================================================
module uart_byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [7:0]            push_data,
  input  logic                  pop,
  output logic [7:0]            head,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  full,
  output logic                  empty
);

  localparam int                  C_DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] C_DEPTH_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2:0] C_CNT_ONE   = (DEPTH_LOG2 + 1)'(1);
  localparam logic [DEPTH_LOG2-1:0] C_PTR_ONE = DEPTH_LOG2'(1);

  logic [7:0]            mem [0:C_DEPTH-1];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == C_DEPTH_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Byte storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers wrap naturally at their width; count tracks net push/pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + C_PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + C_PTR_ONE;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + C_CNT_ONE;
        2'b01:   count <= count - C_CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_buffer
// Brief    : Byte FIFO in front of a UART transmitter. Bytes written by the
//            CPU side are queued and handed to the transmitter one at a time
//            over a DV/done level handshake.
//            Optional feature macro: UART_TX_BUFFER_OVF_FLAG_EN enables the
//            sticky overflow flag (otherwise o_Overflow is tied low).
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_buffer
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2
) (
  input  logic                  i_Clock,
  input  logic                  reset,
  input  logic                  i_Wr_En,
  input  logic [7:0]            i_Wr_Data,
  output logic                  o_Full,
  output logic                  o_Empty,
  output logic [DEPTH_LOG2:0]   o_Count,
  output logic                  o_Busy,
  output logic                  o_Tx_DV,
  output logic [7:0]            o_Tx_Byte,
  input  logic                  i_Tx_Done,
  input  logic                  i_Clr_Ovf,
  output logic                  o_Overflow
);

  tx_state_t  state;
  logic [7:0] head;
  logic       pop;

  uart_byte_fifo #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_fifo (
    .clk       (i_Clock),
    .rst       (reset),
    .push      (i_Wr_En),
    .push_data (i_Wr_Data),
    .pop       (pop),
    .head      (head),
    .count     (o_Count),
    .full      (o_Full),
    .empty     (o_Empty)
  );

  // A new byte leaves the FIFO only when idle and the transmitter has
  // released its done level from the previous byte.
  assign pop    = (state == S_IDLE) && !o_Empty && !i_Tx_Done;
  assign o_Busy = !o_Empty || (state != S_IDLE);

  // Handshake FSM: load byte and raise DV, wait for done, wait for done low.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      state     <= S_IDLE;
      o_Tx_DV   <= 1'b0;
      o_Tx_Byte <= 8'h00;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            o_Tx_Byte <= head;
            o_Tx_DV   <= 1'b1;
            state     <= S_SEND;
          end
        end
        S_SEND: begin
          if (i_Tx_Done) begin
            o_Tx_DV <= 1'b0;
            state   <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          if (!i_Tx_Done) begin
            state <= S_IDLE;
          end
        end
        default: begin
          o_Tx_DV <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_BUFFER_OVF_FLAG_EN
  // Sticky overflow: a dropped write sets it and beats a same-cycle clear.
  always_ff @(posedge i_Clock) begin
    if (reset) begin
      o_Overflow <= 1'b0;
    end else if (i_Wr_En && o_Full) begin
      o_Overflow <= 1'b1;
    end else if (i_Clr_Ovf) begin
      o_Overflow <= 1'b0;
    end
  end
`else
  logic unused_clr_ovf;
  assign unused_clr_ovf = i_Clr_Ovf;
  assign o_Overflow     = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_buffer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx_buffer
// Brief    : Self-checking bench for uart_tx_buffer: queue-based reference
//            model compared every cycle, stub transmitter, directed scenarios
//            and a randomized phase.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx_buffer;
  import uart_pkg::*;

  localparam int DL2   = DEFAULT_DEPTH_LOG2;
  localparam int DEPTH = 1 << DL2;
`ifdef UART_TX_BUFFER_OVF_FLAG_EN
  localparam int OVF_EXP = 1;
`else
  localparam int OVF_EXP = 0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           wr_en = 1'b0;
  logic [7:0]     wr_data = 8'h00;
  logic           tx_done = 1'b0;
  logic           clr_ovf = 1'b0;
  logic           full, empty, busy, tx_dv, ovf;
  logic [DL2:0]   count;
  logic [7:0]     tx_byte;

  always #5 clk = ~clk;

  uart_tx_buffer #(.DEPTH_LOG2(DL2)) dut (
    .i_Clock    (clk),
    .reset      (reset),
    .i_Wr_En    (wr_en),
    .i_Wr_Data  (wr_data),
    .o_Full     (full),
    .o_Empty    (empty),
    .o_Count    (count),
    .o_Busy     (busy),
    .o_Tx_DV    (tx_dv),
    .o_Tx_Byte  (tx_byte),
    .i_Tx_Done  (tx_done),
    .i_Clr_Ovf  (clr_ovf),
    .o_Overflow (ovf)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: queued bytes, byte on the wire, handshake phase flags.
  logic [7:0] mq[$];
  bit         m_dv      = 1'b0;
  bit         m_rel     = 1'b0;
  logic [7:0] m_byte    = 8'h00;
  bit         m_ovf     = 1'b0;

  // Transmitter stub controls.
  bit stub_en   = 1'b1;
  bit stub_rand = 1'b0;
  int stub_lat  = 3;
  int stub_hold = 0;
  int s_cnt     = 0;
  int r_cnt     = 0;

  logic [7:0] emitted[$];
  bit         prev_dv = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock edge using the inputs presented before it.
  task automatic model_edge();
    bit was_full;
    bit was_empty;
    if (reset) begin
      mq.delete();
      m_dv   = 1'b0;
      m_rel  = 1'b0;
      m_byte = 8'h00;
      m_ovf  = 1'b0;
    end else begin
      was_full  = (mq.size() == DEPTH);
      was_empty = (mq.size() == 0);
      if (!m_dv && !m_rel) begin
        if (!was_empty && !tx_done) begin
          m_byte = mq.pop_front();
          m_dv   = 1'b1;
        end
      end else if (m_dv) begin
        if (tx_done) begin
          m_dv  = 1'b0;
          m_rel = 1'b1;
        end
      end else if (!tx_done) begin
        m_rel = 1'b0;
      end
      if (wr_en && !was_full) mq.push_back(wr_data);
`ifdef UART_TX_BUFFER_OVF_FLAG_EN
      if (wr_en && was_full) m_ovf = 1'b1;
      else if (clr_ovf)      m_ovf = 1'b0;
`endif
    end
  endtask

  task automatic compare();
    chk("count",    int'(count),   mq.size());
    chk("empty",    int'(empty),   int'(mq.size() == 0));
    chk("full",     int'(full),    int'(mq.size() == DEPTH));
    chk("busy",     int'(busy),    int'(mq.size() != 0 || m_dv || m_rel));
    chk("tx_dv",    int'(tx_dv),   int'(m_dv));
    chk("tx_byte",  int'(tx_byte), int'(m_byte));
    chk("overflow", int'(ovf),     int'(m_ovf));
  endtask

  // Stub transmitter: done rises stub_lat cycles after DV, falls stub_hold
  // cycles after DV drops; reset clears it along with the buffer.
  task automatic stub_tick();
    if (reset) begin
      tx_done = 1'b0;
      s_cnt   = 0;
      r_cnt   = 0;
    end else if (stub_en) begin
      if (!tx_done) begin
        if (tx_dv) begin
          s_cnt++;
          if (s_cnt >= stub_lat) begin
            tx_done = 1'b1;
            s_cnt   = 0;
          end
        end
      end else if (!tx_dv) begin
        r_cnt++;
        if (r_cnt > stub_hold) begin
          tx_done = 1'b0;
          r_cnt   = 0;
          if (stub_rand) begin
            stub_lat  = $urandom_range(1, 8);
            stub_hold = $urandom_range(0, 3);
          end
        end
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    compare();
    if (tx_dv && !prev_dv) emitted.push_back(tx_byte);
    prev_dv = tx_dv;
    stub_tick();
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((busy || tx_done) && n < 20000) begin
      step();
      n++;
    end
    chk({"drain_", tag}, int'(busy || tx_done), 0);
  endtask

  task automatic write_byte(input logic [7:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int max_cnt;
    int gap;
    int n;

    // Reset state
    step();
    step();
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_full",  int'(full),  0);
    chk("rst_dv",    int'(tx_dv), 0);
    chk("rst_byte",  int'(tx_byte), 0);
    chk("rst_ovf",   int'(ovf),   0);
    chk("rst_state", int'(dut.state), int'(S_IDLE));
    reset = 1'b0;
    step();

    // Single byte: DV two cycles after the write strobe
    stub_lat = 3;
    wr_en = 1'b1; wr_data = 8'h41;
    step();
    wr_en = 1'b0;
    chk("single_cnt1", int'(count), 1);
    chk("single_dv0",  int'(tx_dv), 0);
    step();
    chk("single_dv1",  int'(tx_dv), 1);
    chk("single_byte", int'(tx_byte), 8'h41);
    drain("single");
    chk("single_empty", int'(empty), 1);
    chk("single_idle",  int'(dut.state), int'(S_IDLE));

    // Burst of 16 with a slow transmitter (50 clocks/bit, 10 bits)
    emitted.delete();
    stub_lat = 500;
    max_cnt  = 0;
    for (int i = 1; i <= 16; i++) begin
      write_byte(8'(i));
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
    chk("burst_max_count", max_cnt, 15);
    drain("burst");
    chk("burst_n", emitted.size(), 16);
    for (int i = 0; i < 16 && i < emitted.size(); i++)
      chk("burst_order", int'(emitted[i]), i + 1);

    // Overflow: transmitter holds done, no pops
    stub_lat = 3;
    stub_en  = 1'b0;
    tx_done  = 1'b1;
    emitted.delete();
    for (int i = 0; i < 17; i++) write_byte(8'h80 + 8'(i));
    step();
    chk("ovf_count", int'(count), 16);
    chk("ovf_full",  int'(full), 1);
    chk("ovf_flag",  int'(ovf), OVF_EXP);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_clear", int'(ovf), 0);
    stub_en = 1'b1;
    drain("ovf");
    chk("ovf_n", emitted.size(), 16);
    if (emitted.size() == 16) begin
      chk("ovf_first", int'(emitted[0]), 8'h80);
      chk("ovf_last",  int'(emitted[15]), 8'h8F);
    end

    // Handshake: done held 5 cycles after DV drops
    emitted.delete();
    stub_lat  = 2;
    stub_hold = 5;
    write_byte(8'h5A);
    write_byte(8'hA5);
    n = 0;
    while (!tx_dv && n < 100) begin step(); n++; end
    while (tx_dv && n < 100)  begin step(); n++; end
    gap = 0;
    while (!tx_dv && n < 100) begin gap++; step(); n++; end
    chk("hs_gap", gap, 7);
    chk("hs_byte2", int'(tx_byte), 8'hA5);
    drain("hs");
    stub_hold = 0;

    // Simultaneous push and pop with count 3
    emitted.delete();
    stub_en = 1'b0;
    tx_done = 1'b1;
    write_byte(8'h11);
    write_byte(8'h22);
    write_byte(8'h33);
    chk("sim_pre_cnt", int'(count), 3);
    tx_done = 1'b0;
    stub_en = 1'b1;
    write_byte(8'hAA);
    chk("sim_cnt",  int'(count), 3);
    chk("sim_dv",   int'(tx_dv), 1);
    chk("sim_byte", int'(tx_byte), 8'h11);
    drain("sim");
    chk("sim_n", emitted.size(), 4);
    if (emitted.size() == 4) chk("sim_last", int'(emitted[3]), 8'hAA);

    // Reset in the middle of a transfer
    stub_lat = 100;
    for (int i = 0; i < 6; i++) write_byte(8'h61 + 8'(i));
    chk("mid_cnt5", int'(count), 5);
    chk("mid_dv",   int'(tx_dv), 1);
    reset = 1'b1;
    step();
    chk("mid_rst_dv",    int'(tx_dv), 0);
    chk("mid_rst_cnt",   int'(count), 0);
    chk("mid_rst_empty", int'(empty), 1);
    chk("mid_rst_ovf",   int'(ovf), 0);
    reset = 1'b0;
    step();

    // Randomized traffic with random transmitter timing
    stub_rand = 1'b1;
    stub_lat  = 2;
    for (int c = 0; c < 3000; c++) begin
      wr_en   = ($urandom_range(0, 99) < 45);
      wr_data = 8'($urandom_range(0, 255));
      clr_ovf = ($urandom_range(0, 31) == 0);
      step();
    end
    wr_en   = 1'b0;
    clr_ovf = 1'b0;
    drain("rand");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/uart_tx_buffer.md
UART_TX_BUFFER -- requirements
Module: uart_tx_buffer

Interface
REQ-001 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth = 2**DEPTH_LOG2 bytes (16).
REQ-002 SHALL have reset reset, synchronous, active-high; clock i_Clock.
REQ-003 SHALL have port i_Clock  in  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous active-high reset.
REQ-005 SHALL have port i_Wr_En  in  1  one-cycle write strobe from the CPU/bus side.
REQ-006 SHALL have port i_Wr_Data  in  8  byte to enqueue.
REQ-007 SHALL have port o_Full  out  1  FIFO holds 2**DEPTH_LOG2 bytes.
REQ-008 SHALL have port o_Empty  out  1  FIFO holds 0 bytes.
REQ-009 SHALL have port o_Count  out  DEPTH_LOG2+1  current FIFO occupancy.
REQ-010 SHALL have port o_Busy  out  1  FIFO non-empty or a transmitter handshake in progress.
REQ-011 SHALL have port o_Tx_DV  out  1  data-valid to the UART transmitter.
REQ-012 SHALL have port o_Tx_Byte  out  8  byte to the UART transmitter.
REQ-013 SHALL have port i_Tx_Done  in  1  transmitter done level; held high until o_Tx_DV drops.
REQ-014 SHALL have port i_Clr_Ovf  in  1  clears the overflow flag.
REQ-015 SHALL have port o_Overflow  out  1  sticky flag: a write was attempted while full.

Function
REQ-016 SHALL accept a write when i_Wr_En=1 and o_Full=0, storing i_Wr_Data at the write pointer; o_Count increments at the next edge.
REQ-017 SHALL drop a write when i_Wr_En=1 and o_Full=1, leaving FIFO contents and pointers unchanged.
REQ-018 SHALL wrap read/write pointers modulo 2**DEPTH_LOG2; o_Full/o_Empty derive from o_Count, never from pointer equality alone.
REQ-019 SHALL implement states S_IDLE, S_SEND, S_RELEASE.
REQ-020 In S_IDLE with o_Empty=0 and i_Tx_Done=0, SHALL at the next edge load o_Tx_Byte from the head, advance the read pointer, decrement o_Count, set o_Tx_DV=1, and enter S_SEND.
REQ-021 In S_SEND, SHALL hold o_Tx_DV=1 and o_Tx_Byte stable until i_Tx_Done=1, then clear o_Tx_DV and enter S_RELEASE.
REQ-022 In S_RELEASE, SHALL hold o_Tx_DV=0 until i_Tx_Done=0, then enter S_IDLE.
REQ-023 Latency: a byte written into an empty FIFO in S_IDLE at edge N SHALL see o_Tx_DV=1 after edge N+2.
REQ-024 Simultaneous accepted write and pop in the same cycle SHALL leave o_Count unchanged.
REQ-025 A write to a full FIFO in the cycle a pop occurs SHALL still be dropped, since o_Full is evaluated before the edge.
REQ-026 o_Busy SHALL equal (o_Empty=0) OR (state != S_IDLE).
REQ-027 Bytes SHALL reach o_Tx_Byte in write order, with no duplication or loss except per REQ-017.

Reset
REQ-028 reset SHALL force state S_IDLE, pointers 0, o_Count=0, o_Empty=1, o_Full=0, o_Tx_DV=0, o_Tx_Byte=0, o_Overflow=0.
REQ-029 reset mid-transfer SHALL discard FIFO contents and the in-flight handshake; the transmitter is reset by the same signal.
REQ-030 Storage array contents SHALL NOT require reset.

Configuration
REQ-031 With macro UART_TX_BUFFER_OVF_FLAG_EN defined, o_Overflow SHALL set on a write dropped per REQ-017.
REQ-032 With UART_TX_BUFFER_OVF_FLAG_EN defined, o_Overflow SHALL clear when i_Clr_Ovf=1; a set in the same cycle wins.
REQ-033 Without UART_TX_BUFFER_OVF_FLAG_EN, o_Overflow SHALL be tied 0 and i_Clr_Ovf ignored; all ports remain present.

Structure
REQ-034 State encodings (S_IDLE=2'd0, S_SEND=2'd1, S_RELEASE=2'd2) and the default depth constant SHALL live in shared package uart_pkg.
REQ-035 Byte storage and pointers SHALL be sub-module uart_byte_fifo (sync FIFO with push/pop/count); the handshake FSM stays in uart_tx_buffer.

Verification
REQ-036 SHALL verify single byte: write 0x41 to empty FIFO -> o_Tx_DV high 2 cycles later with o_Tx_Byte=0x41; after stub done, o_Empty=1 and state S_IDLE.
REQ-037 SHALL verify burst: write 0x01..0x10 back-to-back, DEPTH_LOG2=4, stub transmitter at 50 clks/bit -> 16 bytes emitted in order; o_Full seen high only if no pop occurred yet.
REQ-038 SHALL verify overflow: with no pops (hold i_Tx_Done=1), write 17 bytes -> o_Count=16, 17th dropped, o_Overflow=1 if macro defined, else 0; i_Clr_Ovf pulse -> 0.
REQ-039 SHALL verify handshake: hold i_Tx_Done=1 for 5 cycles after o_Tx_DV drops -> no new o_Tx_DV until i_Tx_Done=0, then next byte issues.
REQ-040 SHALL verify simultaneous: write 0xAA in the pop cycle with o_Count=3 -> o_Count stays 3; 0xAA emitted last.
REQ-041 SHALL verify reset mid-transfer: assert reset during S_SEND with o_Count=5 -> next cycle o_Tx_DV=0, o_Count=0, o_Empty=1, o_Overflow=0.
